// File: rtl/ica_pkg.sv
// Shared definitions for the FastICA convergence checker: fixed-point format,
// sequencer states and the saturation helper.
package ica_pkg;

    localparam int FRAC_BITS = 20;
    localparam int ONE_Q     = 1 << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CMP  = 2'd2,
        HALT = 2'd3
    } state_t;

    // Clamp symmetrically to +/-(2^(width-1)-1) so the magnitude never overflows.
    function automatic logic signed [63:0] saturate(input logic signed [127:0] v,
                                                    input int                  width);
        logic signed [127:0] lim;
        lim = (128'sd1 <<< (width - 1)) - 128'sd1;
        if (v > lim) begin
            return 64'(lim);
        end else if (v < -lim) begin
            return 64'(-lim);
        end
        return 64'(v);
    endfunction

endpackage

// File: rtl/ica_dot_mac.sv
// Serial signed multiply-accumulate: one element product per enabled cycle
// into a widened accumulator that cannot overflow over a full vector.
module ica_dot_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 67
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         clear,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] w_a_ext;
    logic signed [2*DATA_WIDTH-1:0] w_b_ext;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;

    assign w_a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign w_b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + ACC_WIDTH'(w_prod);
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/ica_conv_check.sv
// FastICA convergence check: dot product of each new weight vector with the
// previous one, flagging convergence or iteration timeout.
module ica_conv_check
    import ica_pkg::*;
#(
    parameter int DIMENSIONS = 5,
    parameter int DATA_WIDTH = 32,
    parameter int EPS        = 1049,
    parameter int MAX_ITER   = 64,
    parameter int ITER_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             nreset,
    input  logic                             iter_clear,
    input  logic                             w_vld,
    input  logic [DIMENSIONS*DATA_WIDTH-1:0] w_in,
    output logic                             busy,
    output logic                             result_vld,
    output logic                             converged,
    output logic                             timeout,
    output logic [DATA_WIDTH-1:0]            dot_out,
    output logic [ITER_WIDTH-1:0]            iter_count,
    output logic [DIMENSIONS*DATA_WIDTH-1:0] w_final
);

    localparam int VEC_W = DIMENSIONS * DATA_WIDTH;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(DIMENSIONS);
    localparam int IDX_W = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;
    localparam logic signed [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(ONE_Q - EPS);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_accept;
    logic [VEC_W-1:0]        r_w_new;
    logic [VEC_W-1:0]        r_w_old;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_result_vld;
    logic                    r_converged;
    logic                    r_timeout;
    logic [DATA_WIDTH-1:0]   r_dot;
    logic [ITER_WIDTH-1:0]   r_iter;

    logic signed [ACC_W-1:0]      w_acc;
    logic signed [ACC_W-1:0]      w_acc_shift;
    logic signed [DATA_WIDTH-1:0] w_dot;
    logic signed [DATA_WIDTH-1:0] w_abs;
    logic                         w_hit;
    logic [ITER_WIDTH-1:0]        w_iter_next;
    logic                         w_last_iter;

    ica_dot_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .nreset (nreset),
        .clear  (w_accept || iter_clear),
        .en     ((r_state == MAC) && !iter_clear),
        .a      (r_w_new[r_idx*DATA_WIDTH +: DATA_WIDTH]),
        .b      (r_w_old[r_idx*DATA_WIDTH +: DATA_WIDTH]),
        .acc    (w_acc)
    );

    // Truncate to Q.20 and saturate so the absolute value below is always representable.
    assign w_acc_shift = w_acc >>> FRAC_BITS;
    assign w_dot       = DATA_WIDTH'(saturate(128'(w_acc_shift), DATA_WIDTH));
    assign w_abs       = (w_dot < 0) ? -w_dot : w_dot;
    assign w_hit       = (w_abs >= THRESH);
    assign w_iter_next = r_iter + 1'b1;
    assign w_last_iter = (w_iter_next == ITER_WIDTH'(MAX_ITER));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_vld) begin
                    w_accept     = 1'b1;
                    w_next_state = MAC;
                end
            end
            MAC: begin
                if (r_idx == IDX_W'(DIMENSIONS - 1)) begin
                    w_next_state = CMP;
                end
            end
            CMP: begin
                if (w_hit || w_last_iter) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            HALT: begin
                w_next_state = HALT;
            end
        endcase
        if (iter_clear) begin
            w_accept     = 1'b0;
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_w_new      <= '0;
            r_w_old      <= '0;
            r_idx        <= '0;
            r_result_vld <= 1'b0;
            r_converged  <= 1'b0;
            r_timeout    <= 1'b0;
            r_dot        <= '0;
            r_iter       <= '0;
        end else if (iter_clear) begin
            r_w_old      <= '0;
            r_idx        <= '0;
            r_result_vld <= 1'b0;
            r_converged  <= 1'b0;
            r_timeout    <= 1'b0;
            r_dot        <= '0;
            r_iter       <= '0;
        end else begin
            r_result_vld <= 1'b0;
            if (w_accept) begin
                r_w_new <= w_in;
                r_idx   <= '0;
            end else if (r_state == MAC) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == CMP) begin
                r_dot        <= w_dot;
                r_iter       <= w_iter_next;
                r_w_old      <= r_w_new;
                r_result_vld <= 1'b1;
                if (w_hit) begin
                    r_converged <= 1'b1;
                end else if (w_last_iter) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign busy       = (r_state == MAC) || (r_state == CMP);
    assign result_vld = r_result_vld;
    assign converged  = r_converged;
    assign timeout    = r_timeout;
    assign dot_out    = r_dot;
    assign iter_count = r_iter;
    assign w_final    = r_w_old;

endmodule
